block_serializer: RTL
=====================

// Module: block_serializer
// PURPOSE
//  Output stage that sits directly after dematrixify. It takes the flat 128-bit
//  state word (byte k = bits [8k+7:8k]; byte 0 = matrix[0][0], byte 15 = matrix[3][3])
//  and streams it out one byte per transfer, using valid/ready on both sides.
//  A new block is accepted in the same cycle the previous block's last byte
//  leaves, so back-to-back blocks stream with no bubble.
// PARAMETERS
//  BLOCK_BYTES  16  bytes per input block; in_block width = 8*BLOCK_BYTES
//  LSB_FIRST    1   1: emit byte 0 first; 0: emit byte BLOCK_BYTES-1 first
// PORTS
//  clk        in   1                clock; all state changes on rising edge
//  rst_n      in   1                asynchronous reset, active low
//  in_valid   in   1                in_block holds a complete block
//  in_ready   out  1                block accepted at the edge where in_valid && in_ready
//  in_block   in   8*BLOCK_BYTES    flat block from dematrixify (rawstring)
//  out_valid  out  1                out_byte holds a valid byte
//  out_ready  in   1                consumer takes out_byte at the edge where out_valid && out_ready
//  out_byte   out  8                current byte
//  out_last   out  1                high with out_valid on the final byte of a block
//  busy       out  1                high while in SEND state
// BEHAVIOUR
//  Interface
//  - One clock (clk). Reset rst_n is asynchronous and active low.
//  Reset
//  - While rst_n = 0: state = IDLE, shift register = 0, counter = 0.
//  - Outputs out_valid, out_last, busy, in_ready and out_byte are all 0.
//  - Reset takes effect immediately, with no clock edge needed.
//  - Reset mid-block discards the remaining bytes. No partial-block recovery.
//  State machine: IDLE and SEND. Counter cnt is $clog2(BLOCK_BYTES) bits wide.
//  - in_ready is combinational: (state == IDLE) || (out_valid && out_ready && out_last).
//    It is forced to 0 while rst_n = 0.
//  - IDLE, accept: load in_block into the shift register, set cnt = 0, go to SEND.
//    out_valid rises in the next cycle, carrying the first byte.
//    Latency is 1 cycle from acceptance to the first valid byte.
//  - SEND, out_valid && !out_ready: out_byte, out_last and cnt hold stable.
//  - SEND, transfer with cnt < BLOCK_BYTES-1: cnt += 1; the next byte is presented next cycle.
//  - SEND, transfer with cnt = BLOCK_BYTES-1 and in_valid = 1: the new block loads at that edge.
//    cnt becomes 0, the state stays SEND, and the new block's first byte appears next cycle (no bubble).
//  - SEND, transfer with cnt = BLOCK_BYTES-1 and in_valid = 0: go to IDLE; out_valid drops next cycle.
//  Output rules
//  - out_byte = byte cnt when LSB_FIRST = 1, else byte BLOCK_BYTES-1-cnt.
//  - out_byte is registered and is 0 while in IDLE.
//  - out_last = out_valid && (cnt == BLOCK_BYTES-1).
//  - busy = (state == SEND).
//  Boundary rules
//  - in_block is sampled only at the accept edge; changes at any other time are ignored.
//  - cnt never wraps past BLOCK_BYTES-1. The last-byte transfer always reloads cnt or goes to IDLE.
//  - out_valid, once high, must not drop until the transfer completes (AXI-style rule).
//  - out_ready while out_valid = 0 has no effect.
// TESTING
//  1. Hold rst_n = 0 and toggle clk.
//     -> out_valid = out_last = busy = in_ready = 0 and out_byte = 8'h00.
//     Release rst_n -> in_ready = 1.
//  2. Send one block 128'h0F0E0D0C_0B0A0908_07060504_03020100 with out_ready = 1 throughout.
//     -> 16 consecutive bytes 00, 01, ..., 0F, first byte 1 cycle after accept.
//     out_last only on 0F; IDLE afterwards.
//  3. Same block, out_ready toggling 1,0,0,1,... -> out_byte stays stable while stalled.
//     Exactly 16 transfers, same order, no byte dropped or duplicated.
//  4. Two blocks back-to-back (second = first XOR all-8'hFF), in_valid held high.
//     -> 32 consecutive transfers with no idle cycle between the 0F and FF bytes.
//     in_ready pulses on the last-byte cycle.
//  5. LSB_FIRST = 0 with the block from test 2 -> bytes emitted 0F, 0E, ..., 00.
//     out_last on 00.
//  6. Assert rst_n = 0 asynchronously after byte 5 of a block.
//     -> outputs go to 0 immediately. After release, a new block streams from its byte 0.

Source files
------------

// File: rtl/block_serializer.sv
// rtl/block_serializer.sv - byte-wide valid/ready serializer for flat state blocks
// Loads a whole block, then emits one byte per transfer; back-to-back blocks stream with no bubble.
module block_serializer #(
  parameter int BLOCK_BYTES = 16,
  parameter bit LSB_FIRST   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*BLOCK_BYTES-1:0] in_block,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_byte,
  output logic                     out_last,
  output logic                     busy
);

  localparam int W  = 8 * BLOCK_BYTES;
  localparam int CW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BLOCK_BYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  sreg;
  logic [CW-1:0] cnt;
  logic          xfer, last_xfer, load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    xfer      = out_valid && out_ready;
    last_xfer = xfer && (cnt == LAST_CNT);
    // Gated by rst_n so the upstream stage never sees a handshake during reset.
    in_ready  = rst_n && ((state == IDLE) || last_xfer);
    load      = in_valid && in_ready;
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SEND;
      SEND:    if (last_xfer && !in_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The front byte of sreg is always the byte on out_byte; the last shift leaves sreg all-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= in_block;
      cnt  <= '0;
    end else if (last_xfer) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (xfer) begin
      sreg <= LSB_FIRST ? {8'h00, sreg[W-1:8]} : {sreg[W-9:0], 8'h00};
      cnt  <= cnt + CW'(1);
    end
  end

  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign out_last  = out_valid && (cnt == LAST_CNT);
  assign out_byte  = LSB_FIRST ? sreg[7:0] : sreg[W-1 -: 8];

endmodule
